uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the frame state machine.
// Serial line and done pulse are registered, so they lag the state by one cycle.
module uart_tx #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int BIT_CLKS = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BIT_LOAD = CW'(BIT_CLKS - 1);
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_empty, fifo_full, wr_en, rd_en;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            bit_end, line_d, done_d;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign o_tx_ready = !fifo_full;
  // A full FIFO refuses writes even when a pop frees a slot on the same edge.
  assign wr_en      = i_tx_valid && !fifo_full;
  assign bit_end    = (bit_cnt == '0);
  assign rd_en      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));
  assign o_tx_busy  = (state != IDLE) || !fifo_empty;

  always_ff @(posedge i_clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= i_tx_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_tx_serial <= 1'b1;
      o_tx_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_tx_serial <= line_d;
      o_tx_done   <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (rd_en) begin
      shift   <= fifo_mem[rd_ptr];
      bit_cnt <= BIT_LOAD;
    end else if (state != IDLE) begin
      if (bit_end) begin
        bit_cnt <= BIT_LOAD;
        if (state == DATA) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end else begin
          bit_idx <= '0;
        end
      end else begin
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    done_d = 1'b0;
    case (state)
      START:   line_d = 1'b0;
      DATA:    line_d = shift[0];
      STOP:    done_d = bit_end;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BIT_CLKS=10: frame timing, back-to-back FIFO,
// write-while-full drop, mid-frame reset and a 256-byte loopback receiver.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx_serial, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;

  logic        rx_en = 1'b0;
  logic [7:0]  rx_d;
  logic [8:0]  rx_q[$];
  int          done_cnt = 0;
  logic [7:0]  seq [5] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F};

  uart_tx #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(tx_valid), .i_tx_byte(tx_byte),
    .o_tx_ready(tx_ready), .o_tx_serial(tx_serial), .o_tx_busy(tx_busy),
    .o_tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expects the 100 line cycles of one frame starting at the next negedge.
  task automatic check_frame(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("serial", tx_serial, fr[i/10]);
      chk("done", tx_done, (i == 99));
    end
  endtask

  task automatic send_single(input logic [7:0] b);
    tx_valid = 1'b1; tx_byte = b;
    @(negedge clk);
    tx_valid = 1'b0; tx_byte = ~b;
    chk("busy_after_write", tx_busy, 1);
    chk("line_k", tx_serial, 1);
    @(negedge clk);
    chk("line_k1", tx_serial, 1);
    check_frame(b);
    @(negedge clk);
    chk("line_after", tx_serial, 1);
    chk("done_after", tx_done, 0);
    chk("busy_after", tx_busy, 0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    int t;
    t = 0;
    tx_valid = 1'b1; tx_byte = b;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wr_timeout", (t < 2000), 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Behavioural 8N1 receiver: samples each bit mid-period.
  always begin
    @(negedge clk);
    if (rx_en && tx_serial === 1'b0) begin
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        rx_d[i] = tx_serial;
      end
      repeat (10) @(negedge clk);
      rx_q.push_back({~tx_serial, rx_d});
    end
  end

  always @(posedge clk) if (rx_en && tx_done) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int low_seen, done_seen;

    repeat (3) @(negedge clk);
    chk("rst_serial", tx_serial, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", tx_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    send_single(8'hA5);
    repeat (5) @(negedge clk);

    // Back-to-back writes, then a held write while full that meets the first STOP pop.
    tx_valid = 1'b1; tx_byte = seq[0];
    chk("ready_empty", tx_ready, 1);
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          @(negedge clk);
          chk("ready_fill", tx_ready, 1);
          tx_byte = seq[i];
        end
        @(negedge clk);
        chk("ready_full", tx_ready, 0);
        tx_byte = 8'hEE;
        repeat (96) @(negedge clk);
        chk("ready_full_pre_pop", tx_ready, 0);
        @(negedge clk);
        chk("ready_after_pop", tx_ready, 1);
        tx_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 5; j++) check_frame(seq[j]);
      end
    join
    @(negedge clk);
    chk("b2b_line_idle", tx_serial, 1);
    chk("b2b_busy_low", tx_busy, 0);
    chk("b2b_done_low", tx_done, 0);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 of 0x3C, with a second byte buffered.
    tx_valid = 1'b1; tx_byte = 8'h3C;
    @(negedge clk);
    tx_byte = 8'h99;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (43) @(negedge clk);
    chk("bit3_line", tx_serial, 1);
    chk("bit3_busy", tx_busy, 1);
    rst = 1'b1; tx_valid = 1'b1; tx_byte = 8'h77;
    @(negedge clk);
    rst = 1'b0; tx_valid = 1'b0;
    chk("abort_line", tx_serial, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_done", tx_done, 0);
    chk("abort_ready", tx_ready, 1);
    low_seen = 0; done_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) low_seen++;
      if (tx_done !== 1'b0) done_seen++;
    end
    chk("abort_no_frame", low_seen, 0);
    chk("abort_no_done", done_seen, 0);
    send_single(8'h81);
    repeat (5) @(negedge clk);

    // Loopback of 256 bytes through the receiver model.
    rx_en = 1'b1;
    for (int b = 0; b < 256; b++) write_byte(8'(b));
    t = 0;
    while (rx_q.size() < 256 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    chk("rx_count", rx_q.size(), 256);
    chk("tx_done_count", done_cnt, 256);
    for (int i = 0; i < rx_q.size() && i < 256; i++)
      chk("rx_byte", {23'd0, rx_q[i]}, {24'd0, 8'(i)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
